// File: rtl/branch_resolve_pipe.sv
// branch_resolve_pipe: two-stage branch compare/redirect pipeline with valid/ready handshake.
// Define BRANCH_STATS_EN to add the stat_branches/stat_taken/stat_mispredict counters.
module branch_resolve_pipe #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   data_in1,
    input  logic [XLEN-1:0]   data_in2,
    input  logic [2:0]        branch_op,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              pred_taken,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              branch_out,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              illegal_op
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_mispredict
`endif
);
    logic            s1_valid, s2_valid, s1_pred;
    logic [2:0]      s1_op;
    logic [XLEN-1:0] s1_d1, s1_d2, s1_pc, s1_imm;
    logic            s2_load, accept, eq, lt, ltu, taken, illegal;

    assign out_valid = s2_valid;

    always_comb begin
        s2_load  = !s2_valid || out_ready;
        in_ready = !s1_valid || s2_load;
        accept   = in_valid && in_ready && !flush;
        eq       = s1_d1 == s1_d2;
        lt       = $signed(s1_d1) < $signed(s1_d2);
        ltu      = s1_d1 < s1_d2;
        illegal  = s1_op[2:1] == 2'b01;
        // funct3[0] inverts the base comparison; funct3[1] picks unsigned when funct3[2] is set
        taken    = s1_op[2] ? ((s1_op[1] ? ltu : lt) ^ s1_op[0]) : (!illegal && (eq ^ s1_op[0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            branch_out  <= 1'b0;
            mispredict  <= 1'b0;
            illegal_op  <= 1'b0;
            redirect_pc <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    branch_out  <= taken;
                    mispredict  <= illegal || (taken != s1_pred);
                    illegal_op  <= illegal;
                    redirect_pc <= taken ? s1_pc + s1_imm : s1_pc + XLEN'(4);
                end
            end
            if (in_ready) s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_d1   <= data_in1;
            s1_d2   <= data_in2;
            s1_op   <= branch_op;
            s1_pc   <= pc;
            s1_imm  <= imm;
            s1_pred <= pred_taken;
        end
    end

`ifdef BRANCH_STATS_EN
    logic consume;
    assign consume = s2_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches   <= '0;
            stat_taken      <= '0;
            stat_mispredict <= '0;
        end else if (consume) begin
            stat_branches   <= stat_branches + STAT_W'(1);
            stat_taken      <= stat_taken + STAT_W'(branch_out);
            stat_mispredict <= stat_mispredict + STAT_W'(mispredict);
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_pipe.sv
// tb_branch_resolve_pipe: table-driven scoreboard bench for branch_resolve_pipe.
module tb_branch_resolve_pipe;
    localparam int XLEN   = 32;
    localparam int STAT_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [XLEN-1:0]   data_in1 = '0, data_in2 = '0, pc = '0, imm = '0;
    logic [2:0]        branch_op = '0;
    logic              pred_taken = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              branch_out, mispredict, illegal_op;
    logic [XLEN-1:0]   redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_branches, stat_taken, stat_mispredict;
`endif

    branch_resolve_pipe #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in1(data_in1), .data_in2(data_in2), .branch_op(branch_op),
        .pc(pc), .imm(imm), .pred_taken(pred_taken), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .branch_out(branch_out),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .illegal_op(illegal_op)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_mispredict(stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d1, d2;
        logic [2:0]  op;
        logic [31:0] pc, imm;
        logic        pred, t, m, ill;
        logic [31:0] rpc;
    } vec_t;

    typedef struct {
        logic        t, m, ill;
        logic [31:0] rpc;
        int          acc;
        bit          lat;
    } exp_t;

    vec_t tbl[14];
    vec_t bp[3];
    exp_t sbq[$];
    int   errs = 0, checks = 0;
    int   mb = 0, mt = 0, mm = 0;
    int   acc;
    logic [STAT_W-1:0] sm;

    function automatic vec_t mk(logic [31:0] d1, logic [31:0] d2, logic [2:0] op, logic [31:0] p,
                                logic [31:0] i, logic pr, logic t, logic m, logic ill, logic [31:0] r);
        vec_t v;
        v.d1 = d1; v.d2 = d2; v.op = op; v.pc = p; v.imm = i;
        v.pred = pr; v.t = t; v.m = m; v.ill = ill; v.rpc = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        data_in1 = v.d1; data_in2 = v.d2; branch_op = v.op;
        pc = v.pc; imm = v.imm; pred_taken = v.pred;
    endtask

    task automatic push(input vec_t v, input bit lat);
        exp_t e;
        e.t = v.t; e.m = v.m; e.ill = v.ill; e.rpc = v.rpc; e.acc = cyc; e.lat = lat;
        sbq.push_back(e);
    endtask

    task automatic monitor_step();
        exp_t e;
        if (!rst && out_valid && out_ready && !flush) begin
            if (sbq.size() == 0) begin
                checks++; errs++;
                $display("FAIL unexpected_result: got out_valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("branch_out", 64'(branch_out), 64'(e.t));
                chk("mispredict", 64'(mispredict), 64'(e.m));
                chk("illegal_op", 64'(illegal_op), 64'(e.ill));
                chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
                if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
                mb++;
                if (e.t) mt++;
                if (e.m) mm++;
            end
        end
    endtask

    // Present v, wait (bounded) for acceptance, optionally scoreboard it.
    task automatic send(input vec_t v, input bit do_push, input bit lat, input bit now);
        drive(v);
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (n == 0 && now) chk("in_ready_b2b", 64'(in_ready), 64'd1);
            if (in_ready) break;
        end
        if (!in_ready) begin
            checks++; errs++;
            $display("FAIL accept_timeout: got in_ready=0 expected acceptance");
        end else if (do_push) push(v, lat);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sbq.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            checks++; errs++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        tbl[0]  = mk(32'hff786510, 32'h1096bc81, 3'b000, 32'h100, 32'h40, 0, 0, 0, 0, 32'h104);
        tbl[1]  = mk(32'hff786510, 32'h1096bc81, 3'b001, 32'h100, 32'h40, 0, 1, 1, 0, 32'h140);
        tbl[2]  = mk(32'hff786510, 32'h1096bc81, 3'b100, 32'h100, 32'h40, 0, 1, 1, 0, 32'h140);
        tbl[3]  = mk(32'hff786510, 32'h1096bc81, 3'b101, 32'h100, 32'h40, 0, 0, 0, 0, 32'h104);
        tbl[4]  = mk(32'hff786510, 32'h1096bc81, 3'b110, 32'h100, 32'h40, 0, 0, 0, 0, 32'h104);
        tbl[5]  = mk(32'hff786510, 32'h1096bc81, 3'b111, 32'h100, 32'h40, 0, 1, 1, 0, 32'h140);
        tbl[6]  = mk(32'h12345678, 32'h12345678, 3'b000, 32'h1000, 32'hfffffff0, 1, 1, 0, 0, 32'h00000ff0);
        tbl[7]  = mk(32'h497bdc52, 32'he6ba817f, 3'b110, 32'hfffffffc, 32'h10, 0, 1, 1, 0, 32'h0000000c);
        tbl[8]  = mk(32'h1, 32'h1, 3'b010, 32'h200, 32'h80, 0, 0, 1, 1, 32'h204);
        tbl[9]  = mk(32'h1, 32'h2, 3'b011, 32'hfffffffc, 32'h8, 1, 0, 1, 1, 32'h0);
        tbl[10] = mk(32'h80000000, 32'h7fffffff, 3'b100, 32'h300, 32'hfffffffc, 1, 1, 0, 0, 32'h2fc);
        tbl[11] = mk(32'h80000000, 32'h7fffffff, 3'b110, 32'h300, 32'hfffffffc, 1, 0, 1, 0, 32'h304);
        tbl[12] = mk(32'h5, 32'h5, 3'b101, 32'h400, 32'h20, 0, 1, 1, 0, 32'h420);
        tbl[13] = mk(32'h5, 32'h5, 3'b111, 32'h400, 32'h20, 1, 1, 0, 0, 32'h420);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_branch_out", 64'(branch_out), 64'd0);
        chk("rst_mispredict", 64'(mispredict), 64'd0);
        chk("rst_illegal_op", 64'(illegal_op), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
`ifdef BRANCH_STATS_EN
        chk("rst_stat_branches", 64'(stat_branches), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // all vectors back-to-back at full rate
        for (int i = 0; i < 14; i++) send(tbl[i], 1, 1, 1);
        drain();

        // backpressure: only two fit while the output is stalled
        bp[0] = tbl[1]; bp[1] = tbl[7]; bp[2] = tbl[8];
        out_ready = 1'b0;
        acc = 0;
        drive(bp[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_branch_out", 64'(branch_out), 64'(bp[0].t));
                chk("bp_hold_redirect_pc", 64'(redirect_pc), 64'(bp[0].rpc));
            end
            if (in_ready && acc < 3) begin
                push(bp[acc], 0);
                acc++;
            end
            @(posedge clk); #1;
            if (acc < 3) drive(bp[acc]);
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        send(bp[2], 1, 0, 0);
        drain();

        // illegal op bumps the mispredict counter by one
`ifdef BRANCH_STATS_EN
        sm = stat_mispredict;
`endif
        send(tbl[8], 1, 1, 1);
        drain();
`ifdef BRANCH_STATS_EN
        chk("stat_mispredict_inc", 64'(stat_mispredict), 64'(sm + STAT_W'(1)));
`endif

        // flush with two in flight, plus a request offered in the flush cycle
        send(tbl[2], 0, 0, 1);
        send(tbl[5], 0, 0, 1);
        flush = 1'b1;
        drive(tbl[6]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("flush_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(tbl[6], 1, 1, 1);
        drain();

`ifdef BRANCH_STATS_EN
        chk("stat_branches", 64'(stat_branches), 64'(mb));
        chk("stat_taken", 64'(stat_taken), 64'(mt));
        chk("stat_mispredict", 64'(stat_mispredict), 64'(mm));
`endif

        // reset mid-operation discards everything in flight
        send(tbl[0], 0, 0, 1);
        send(tbl[1], 0, 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_out_valid", 64'(out_valid), 64'd0);
        end
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
`ifdef BRANCH_STATS_EN
        chk("midrst_stat_branches", 64'(stat_branches), 64'd0);
        chk("midrst_stat_mispredict", 64'(stat_mispredict), 64'd0);
`endif
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_pipe.md
BRANCH_RESOLVE_PIPE -- requirements
Module: branch_resolve_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand, PC and immediate width (legal values 8..64).
REQ-002 The block SHALL have parameter STAT_W, default 32, giving the statistics counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port data_in1, input, XLEN bits: rs1 operand.
REQ-008 The block SHALL have port data_in2, input, XLEN bits: rs2 operand.
REQ-009 The block SHALL have port branch_op, input, 3 bits: BEQ/BNE/BLT/BGE/BLTU/BGEU per the defines.vh macros (funct3 000/001/100/101/110/111).
REQ-010 The block SHALL have port pc, input, XLEN bits: branch instruction address.
REQ-011 The block SHALL have port imm, input, XLEN bits: sign-extended branch offset.
REQ-012 The block SHALL have port pred_taken, input, 1 bit: front-end prediction.
REQ-013 The block SHALL have port flush, input, 1 bit: kill all in-flight requests.
REQ-014 The block SHALL have port out_valid, output, 1 bit: a result is present.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-016 The block SHALL have port branch_out, output, 1 bit: the branch is taken.
REQ-017 The block SHALL have port mispredict, output, 1 bit: branch_out differs from pred_taken, or the op is illegal.
REQ-018 The block SHALL have port redirect_pc, output, XLEN bits: the correct next PC.
REQ-019 The block SHALL have port illegal_op, output, 1 bit: branch_op was 010 or 011.

Function
REQ-020 The block SHALL be a two-stage pipeline: S1 registers the request; S2 registers compare result, redirect_pc and mispredict.
REQ-021 A request SHALL be accepted on a cycle with in_valid && in_ready && !flush.
REQ-022 out_valid SHALL rise exactly 2 cycles after acceptance when out_ready is held high.
REQ-023 A result SHALL be consumed on out_valid && out_ready; outputs SHALL hold stable while out_valid && !out_ready.
REQ-024 S2 SHALL load when it is empty or being consumed; S1 SHALL advance under the same condition.
REQ-025 in_ready SHALL equal !S1_valid || S1 advancing (combinational), giving full throughput of 1 per cycle.
REQ-026 BEQ/BNE SHALL compare equality; BLT/BGE SHALL compare signed XLEN; BLTU/BGEU SHALL compare unsigned.
REQ-027 Taken: redirect_pc = pc + imm, modulo 2^XLEN (wrap-around, no overflow flag).
REQ-028 Not taken: redirect_pc = pc + 4, modulo 2^XLEN.
REQ-029 Illegal op: branch_out=0, illegal_op=1, mispredict=1, redirect_pc = pc + 4.
REQ-030 flush SHALL clear S1_valid and S2_valid next cycle; a request presented in the flush cycle SHALL be dropped.
REQ-031 flush together with out_ready in the same cycle SHALL NOT count as a consumed result.

Reset
REQ-032 With rst high at a clock edge, S1_valid, S2_valid, out_valid, branch_out, mispredict and illegal_op SHALL be 0.
REQ-033 With rst high at a clock edge, redirect_pc SHALL be 0; in_ready SHALL be 1 in the cycle after reset.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight requests with no result emitted.
REQ-035 rst SHALL take priority over flush and handshakes.

Configuration
REQ-036 Macro BRANCH_STATS_EN SHALL gate output ports stat_branches, stat_taken and stat_mispredict (each STAT_W bits, output).
REQ-037 Each stat counter SHALL increment on each consumed result meeting its condition: any, branch_out, mispredict respectively.
REQ-038 The stat counters SHALL wrap at 2^STAT_W and SHALL reset to 0.
REQ-039 Without BRANCH_STATS_EN, the stat ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-040 The bench SHALL drive data1=ff786510, data2=1096bc81 through all six ops back-to-back with out_ready=1 -> branch_out 0,1,1,0,0,1, one result per cycle after 2-cycle latency.
REQ-041 The bench SHALL drive data1=data2=12345678 with pred_taken=1, BEQ, pc=1000, imm=fffffff0 -> branch_out=1, mispredict=0, redirect_pc=00000ff0.
REQ-042 The bench SHALL drive data1=497bdc52, data2=e6ba817f, BLTU, pred_taken=0, pc=fffffffc -> branch_out=1, mispredict=1, redirect_pc=pc+imm wrapped.
REQ-043 The bench SHALL hold out_ready=0 for 5 cycles with 3 requests offered -> exactly 2 accepted, in_ready=0, outputs stable; all 3 delivered in order after release.
REQ-044 The bench SHALL assert flush with 2 requests in flight -> no out_valid for them; the next request has 2-cycle latency.
REQ-045 The bench SHALL drive branch_op=010 -> illegal_op=1, mispredict=1, redirect_pc=pc+4; with BRANCH_STATS_EN, stat_mispredict increments by 1.
